// File: rtl/counter_pkg.sv
// Shared types and elaboration helpers for the up/down step counter family.
package counter_pkg;

    typedef enum logic {
        CNT_WRAP = 1'b0,
        CNT_SAT  = 1'b1
    } cnt_mode_e;

    // Ceiling log2; returns at least 1 so the result is usable as a bus width.
    function automatic int clog2_w(input longint unsigned v);
        int r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Width of the signed intermediate sum: one guard bit for carry, one for sign.
    function automatic int step_width(input int width);
        return width + 2;
    endfunction

    // A single step must never be able to wrap more than once.
    function automatic bit params_legal(input int width, input int inc_size,
                                        input int dec_size, input longint unsigned max_val);
        longint unsigned inc_max;
        longint unsigned dec_max;
        longint unsigned cnt_max;
        inc_max = (longint'(1) << inc_size) - 1;
        dec_max = (longint'(1) << dec_size) - 1;
        cnt_max = (longint'(1) << width) - 1;
        return (width > 0) && (inc_max <= max_val) && (dec_max <= max_val)
               && (max_val <= cnt_max);
    endfunction

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count computation with wrap/saturate boundary handling.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               INC_SIZE = 4,
    parameter int               DEC_SIZE = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}}
) (
    input  logic [WIDTH-1:0]    count,
    input  logic [INC_SIZE-1:0] inc,
    input  logic [DEC_SIZE-1:0] dec,
    input  cnt_mode_e           mode,
    output logic [WIDTH-1:0]    next,
    output logic                ovf_nxt,
    output logic                unf_nxt
);

    localparam int SW = step_width(WIDTH);

    logic [SW-1:0] sum;
    logic [SW-1:0] max_ext;

    assign max_ext = SW'(MAX_VAL);

    always_comb begin
        sum     = SW'(count) + SW'(inc) - SW'(dec);
        next    = WIDTH'(sum);
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        // The top bit of sum is the sign: a negative result is an underflow.
        if (sum[SW-1]) begin
            unf_nxt = 1'b1;
            next    = (mode == CNT_SAT) ? '0 : WIDTH'(sum + max_ext + SW'(1));
        end else if (sum > max_ext) begin
            ovf_nxt = 1'b1;
            next    = (mode == CNT_SAT) ? MAX_VAL : WIDTH'(sum - max_ext - SW'(1));
        end
    end

endmodule

// File: rtl/updown_counter.sv
// Up/down step counter with programmable bound, wrap/saturate and load.
// Optional sticky threshold flag enabled by defining UPDOWN_COUNTER_THRESH_EN.
module updown_counter
    import counter_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               INC_SIZE = 4,
    parameter int               DEC_SIZE = 4,
    parameter int               SATURATE = 0,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [INC_SIZE-1:0] inc,
    input  logic [DEC_SIZE-1:0] dec,
`ifdef UPDOWN_COUNTER_THRESH_EN
    input  logic [WIDTH-1:0]    thresh,
    input  logic                thr_clr,
    output logic                thr_hit,
`endif
    output logic [WIDTH-1:0]    count,
    output logic                ovf,
    output logic                unf,
    output logic                at_max,
    output logic                at_zero
);

    generate
        if (!params_legal(WIDTH, INC_SIZE, DEC_SIZE, longint'(MAX_VAL))) begin : g_illegal
            $error("updown_counter: step sizes exceed MAX_VAL or MAX_VAL exceeds WIDTH");
        end
    endgenerate

    localparam cnt_mode_e MODE = (SATURATE != 0) ? CNT_SAT : CNT_WRAP;

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             at_max_q, at_max_d;
    logic             at_zero_q, at_zero_d;

    logic [WIDTH-1:0] step_next;
    logic             step_ovf;
    logic             step_unf;

    counter_step_calc #(
        .WIDTH    (WIDTH),
        .INC_SIZE (INC_SIZE),
        .DEC_SIZE (DEC_SIZE),
        .MAX_VAL  (MAX_VAL)
    ) u_step (
        .count   (count_q),
        .inc     (inc),
        .dec     (dec),
        .mode    (MODE),
        .next    (step_next),
        .ovf_nxt (step_ovf),
        .unf_nxt (step_unf)
    );

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            count_d = step_next;
            ovf_d   = step_ovf;
            unf_d   = step_unf;
        end
        // Flags are derived from the next count so they land on the same edge.
        at_max_d  = (count_d == MAX_VAL);
        at_zero_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            at_max_q  <= 1'b0;
            at_zero_q <= 1'b1;
        end else begin
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            at_max_q  <= at_max_d;
            at_zero_q <= at_zero_d;
        end
    end

    assign count   = count_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;
    assign at_max  = at_max_q;
    assign at_zero = at_zero_q;

`ifdef UPDOWN_COUNTER_THRESH_EN
    logic thr_hit_q, thr_hit_d;

    always_comb begin
        thr_hit_d = thr_hit_q;
        if (thr_clr) begin
            thr_hit_d = 1'b0;
        end
        if ((count_d >= thresh) && (count_q < thresh)) begin
            thr_hit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_hit_q <= 1'b0;
        end else begin
            thr_hit_q <= thr_hit_d;
        end
    end

    assign thr_hit = thr_hit_q;
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed, table-driven bench for updown_counter across wrap, saturate and clamp builds.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [3:0] inc = '0;
    logic [3:0] dec = '0;
`ifdef UPDOWN_COUNTER_THRESH_EN
    logic [7:0] thresh = 8'd20;
    logic       thr_clr = 1'b0;
    logic [2:0] thr_hit;
`endif

    logic [7:0] cnt [3];
    logic       ovf [3];
    logic       unf [3];
    logic       amax [3];
    logic       azero [3];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    // 0: wrap at 99, 1: saturate at 255, 2: wrap at 150
    updown_counter #(.WIDTH(8), .INC_SIZE(4), .DEC_SIZE(4), .SATURATE(0), .MAX_VAL(8'd99)) dut_w (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .inc(inc), .dec(dec),
`ifdef UPDOWN_COUNTER_THRESH_EN
        .thresh(thresh), .thr_clr(thr_clr), .thr_hit(thr_hit[0]),
`endif
        .count(cnt[0]), .ovf(ovf[0]), .unf(unf[0]), .at_max(amax[0]), .at_zero(azero[0]));

    updown_counter #(.WIDTH(8), .INC_SIZE(4), .DEC_SIZE(4), .SATURATE(1), .MAX_VAL(8'd255)) dut_s (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .inc(inc), .dec(dec),
`ifdef UPDOWN_COUNTER_THRESH_EN
        .thresh(thresh), .thr_clr(thr_clr), .thr_hit(thr_hit[1]),
`endif
        .count(cnt[1]), .ovf(ovf[1]), .unf(unf[1]), .at_max(amax[1]), .at_zero(azero[1]));

    updown_counter #(.WIDTH(8), .INC_SIZE(4), .DEC_SIZE(4), .SATURATE(0), .MAX_VAL(8'd150)) dut_c (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .inc(inc), .dec(dec),
`ifdef UPDOWN_COUNTER_THRESH_EN
        .thresh(thresh), .thr_clr(thr_clr), .thr_hit(thr_hit[2]),
`endif
        .count(cnt[2]), .ovf(ovf[2]), .unf(unf[2]), .at_max(amax[2]), .at_zero(azero[2]));

    typedef struct {
        logic       ld;
        logic [7:0] lv;
        logic       en;
        logic [3:0] inc;
        logic [3:0] dec;
        logic [7:0] c;
        logic       o;
        logic       u;
        logic       mx;
        logic       z;
    } vec_t;

    vec_t tw [12];
    vec_t ts [9];
    vec_t tc [9];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic check_all(input string tag, input int d, input vec_t v);
        chk({tag, ".count"}, int'(cnt[d]), int'(v.c));
        chk({tag, ".ovf"}, int'(ovf[d]), int'(v.o));
        chk({tag, ".unf"}, int'(unf[d]), int'(v.u));
        chk({tag, ".at_max"}, int'(amax[d]), int'(v.mx));
        chk({tag, ".at_zero"}, int'(azero[d]), int'(v.z));
        $display("dut%0d %s ld=%0d lv=%0d en=%0d inc=%0d dec=%0d -> count=%0d ovf=%0d unf=%0d max=%0d zero=%0d",
                 d, tag, v.ld, v.lv, v.en, v.inc, v.dec, cnt[d], ovf[d], unf[d], amax[d], azero[d]);
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        load = v.ld; load_val = v.lv; en = v.en; inc = v.inc; dec = v.dec;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; load = 0; en = 0; inc = 0; dec = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        //            ld lv   en inc dec   c   o  u  mx z
        tw[0]  = '{1, 97,  0, 0,  0,   97, 0, 0, 0, 0};
        tw[1]  = '{0, 0,   1, 5,  0,   2,  1, 0, 0, 0};
        tw[2]  = '{0, 0,   1, 0,  0,   2,  0, 0, 0, 0};
        tw[3]  = '{0, 0,   1, 0,  1,   1,  0, 0, 0, 0};
        tw[4]  = '{0, 0,   1, 0,  4,   97, 0, 1, 0, 0};
        tw[5]  = '{0, 0,   1, 2,  0,   99, 0, 0, 1, 0};
        tw[6]  = '{1, 200, 1, 3,  0,   99, 0, 0, 1, 0};
        tw[7]  = '{0, 0,   0, 15, 2,   99, 0, 0, 1, 0};
        tw[8]  = '{0, 0,   1, 15, 15,  99, 0, 0, 1, 0};
        tw[9]  = '{0, 0,   1, 0,  15,  84, 0, 0, 0, 0};
        tw[10] = '{1, 0,   0, 0,  0,   0,  0, 0, 0, 1};
        tw[11] = '{0, 0,   1, 0,  15,  85, 0, 1, 0, 0};

        ts[0] = '{1, 250, 0, 0,  0,  250, 0, 0, 0, 0};
        ts[1] = '{0, 0,   1, 15, 0,  255, 1, 0, 1, 0};
        ts[2] = '{0, 0,   1, 1,  0,  255, 1, 0, 1, 0};
        ts[3] = '{0, 0,   0, 1,  0,  255, 0, 0, 1, 0};
        ts[4] = '{1, 3,   0, 0,  0,  3,   0, 0, 0, 0};
        ts[5] = '{0, 0,   1, 0,  15, 0,   0, 1, 0, 1};
        ts[6] = '{0, 0,   1, 0,  1,  0,   0, 1, 0, 1};
        ts[7] = '{0, 0,   1, 7,  7,  0,   0, 0, 0, 1};
        ts[8] = '{0, 0,   1, 15, 5,  10,  0, 0, 0, 0};

        tc[0] = '{1, 10,  0, 0,  0,  10,  0, 0, 0, 0};
        tc[1] = '{0, 0,   1, 7,  7,  10,  0, 0, 0, 0};
        tc[2] = '{1, 200, 1, 3,  0,  150, 0, 0, 1, 0};
        for (int i = 3; i < 8; i++) tc[i] = '{0, 0, 0, 15, 2, 150, 0, 0, 1, 0};
        tc[8] = '{0, 0,   1, 1,  0,  0,   1, 0, 0, 1};

        // Reset values while rst is held
        #12;
        for (int d = 0; d < 3; d++)
            check_all("reset", d, '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
        do_reset();

        foreach (tw[i]) begin apply(tw[i]); check_all($sformatf("wrap[%0d]", i), 0, tw[i]); end
        do_reset();
        foreach (ts[i]) begin apply(ts[i]); check_all($sformatf("sat[%0d]", i), 1, ts[i]); end
        do_reset();
        foreach (tc[i]) begin apply(tc[i]); check_all($sformatf("clamp[%0d]", i), 2, tc[i]); end

        // Asynchronous reset mid-count, then first update on the first edge after release
        apply('{1, 37, 0, 0, 0, 37, 0, 0, 0, 0});
        chk("pre_rst.count", int'(cnt[2]), 37);
        @(negedge clk);
        load = 0; en = 1; inc = 1; dec = 0;
        #2 rst = 1'b1;
        #1;
        chk("async_rst.count", int'(cnt[2]), 0);
        chk("async_rst.at_zero", int'(azero[2]), 1);
        $display("async reset between edges -> count=%0d at_zero=%0d", cnt[2], azero[2]);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold.count", int'(cnt[2]), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release.count", int'(cnt[2]), 1);
        chk("rst_release.at_zero", int'(azero[2]), 0);
        $display("first edge after release -> count=%0d", cnt[2]);

`ifdef UPDOWN_COUNTER_THRESH_EN
        @(negedge clk);
        en = 0; thr_clr = 1;
        @(posedge clk); #1;
        chk("thr_clr0.thr_hit", int'(thr_hit[2]), 0);
        @(negedge clk); thr_clr = 0;
        apply('{1, 18, 0, 0, 0, 18, 0, 0, 0, 0});
        chk("thr_load18.thr_hit", int'(thr_hit[2]), 0);
        apply('{0, 0, 1, 3, 0, 21, 0, 0, 0, 0});
        chk("thr_cross.count", int'(cnt[2]), 21);
        chk("thr_cross.thr_hit", int'(thr_hit[2]), 1);
        apply('{0, 0, 1, 0, 15, 6, 0, 0, 0, 0});
        apply('{0, 0, 1, 0, 1, 5, 0, 0, 0, 0});
        chk("thr_sticky.count", int'(cnt[2]), 5);
        chk("thr_sticky.thr_hit", int'(thr_hit[2]), 1);
        apply('{1, 19, 0, 0, 0, 19, 0, 0, 0, 0});
        @(negedge clk);
        en = 1; inc = 3; dec = 0; thr_clr = 1;
        @(posedge clk); #1;
        chk("thr_setwins.count", int'(cnt[2]), 22);
        chk("thr_setwins.thr_hit", int'(thr_hit[2]), 1);
        @(negedge clk);
        en = 0; inc = 0; thr_clr = 1;
        @(posedge clk); #1;
        chk("thr_clr.thr_hit", int'(thr_hit[2]), 0);
        $display("threshold sequence done thr_hit=%0d count=%0d", thr_hit[2], cnt[2]);
        @(negedge clk); thr_clr = 0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/updown_counter.md
Name: updown_counter

Overview:
Parametrised up/down step counter, next generation of the team's single-step counter. Adds multi-bit step amounts, net simultaneous increment and decrement, and a programmable upper bound. Adds wrap or saturate mode, synchronous load, and registered boundary flags. Used as a credit, occupancy and event counter in datapath and control blocks.

Parameters:
WIDTH, 8, count register width in bits.
INC_SIZE, 4, width of the unsigned increment step input.
DEC_SIZE, 4, width of the unsigned decrement step input.
SATURATE, 0, 0 = modulo wrap at the bound, 1 = clamp at 0 / MAX_VAL.
MAX_VAL, 2^WIDTH-1, inclusive upper bound of count. Legal range: 2^INC_SIZE-1 <= MAX_VAL and 2^DEC_SIZE-1 <= MAX_VAL.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
en  in  1  qualifies the inc/dec update.
load  in  1  synchronous load strobe.
load_val  in  WIDTH  value loaded when load=1.
inc  in  INC_SIZE  unsigned increment amount; 0 = no increment.
dec  in  DEC_SIZE  unsigned decrement amount; 0 = no decrement.
count  out  WIDTH  current count, registered.
ovf  out  1  one-cycle pulse: the update crossed above MAX_VAL.
unf  out  1  one-cycle pulse: the update crossed below 0.
at_max  out  1  registered, count == MAX_VAL.
at_zero  out  1  registered, count == 0.

Behaviour:
- Reset (asynchronous, rst=1):
  - count=0, ovf=0, unf=0, at_max=0, at_zero=1.
  - Takes effect immediately and overrides any in-flight update.
  - First update after deassertion occurs on the first rising clk edge with rst=0.
- Priority per edge: rst > load > en.
- load=1:
  - count <= min(load_val, MAX_VAL).
  - ovf=0, unf=0.
  - inc/dec ignored that cycle.
- en=1, load=0:
  - Compute s = count + inc - dec, signed, WIDTH+2 bits, no intermediate truncation.
  - inc and dec in the same cycle net together: inc=3, dec=3 leaves count unchanged with no flags.
- Boundary handling for s:
  - 0 <= s <= MAX_VAL: count <= s.
  - s > MAX_VAL:
    - ovf pulses 1 for one cycle.
    - SATURATE=0: count <= s-(MAX_VAL+1).
    - SATURATE=1: count <= MAX_VAL.
  - s < 0:
    - unf pulses 1 for one cycle.
    - SATURATE=0: count <= s+(MAX_VAL+1).
    - SATURATE=1: count <= 0.
  - The parameter legality rule guarantees at most one wrap per cycle.
- en=0, load=0: count holds; ovf=0 and unf=0.
- Latency: count, ovf, unf, at_max and at_zero all update on the same edge; one cycle from input to output. No combinational path from inputs to outputs.
- Saturate mode while already at the bound: a further increase at MAX_VAL (or decrease at 0) still pulses ovf (unf); count unchanged.

Optional Feature:
Macro UPDOWN_COUNTER_THRESH_EN.
- Defined: adds three ports.
  - thresh  in  WIDTH: threshold value.
  - thr_clr  in  1: clears the sticky flag.
  - thr_hit  out  1: sticky flag, reset value 0.
- thr_hit sets on the edge where the next count is >= thresh and the current count is < thresh (upward crossing; also set by load).
- thr_clr=1 clears thr_hit. If set and clear occur in the same cycle, set wins.
- rst clears thr_hit.
- Undefined: the three ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package counter_pkg holds:
  - typedef cnt_mode_e {CNT_WRAP, CNT_SAT}.
  - function clog2-style width helpers.
  - parameter-legality check function, used by an elaboration-time assertion.
- Sub-module counter_step_calc: purely combinational.
  - Inputs: count, inc, dec, mode.
  - Outputs: next value, ovf_nxt, unf_nxt.
  - Keeps the top level as registers plus priority logic.

Test Plan:
1. Reset mid-count: count=37, assert rst between edges -> count=0, at_zero=1 immediately (before the next edge); hold rst 3 cycles, release -> first update on the next edge.
2. Wrap with WIDTH=8, MAX_VAL=99, SATURATE=0: count=97, inc=5, en=1 -> count=2, ovf=1 for exactly one cycle; then count=1, dec=4 -> count=97, unf=1.
3. Saturate with SATURATE=1, MAX_VAL=255: count=250, inc=15 -> count=255, ovf=1, at_max=1; next cycle inc=1 -> count=255, ovf=1 again; dec=15 from count=3 -> count=0, unf=1, at_zero=1.
4. Simultaneous and priority: count=10, inc=7, dec=7 -> count=10, no flags; load=1, load_val=200, MAX_VAL=150, en=1, inc=3 -> count=150, at_max=1, ovf=0.
5. Hold: en=0 with inc=15, dec=2 for 5 cycles -> count unchanged, ovf=0, unf=0.
6. UPDOWN_COUNTER_THRESH_EN defined, thresh=20: count=18, inc=3 -> count=21, thr_hit=1, and stays 1 through a later decrement to 5; thr_clr=1 coinciding with 19->22 -> thr_hit stays 1; thr_clr alone -> thr_hit=0.
